// File: rtl/arith_pkg.sv
// Shared opcode, FSM state and iteration-mode encodings for the sequential arithmetic unit.
package arith_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD = 2'd0;
  localparam op_t OP_SUB = 2'd1;
  localparam op_t OP_MUL = 2'd2;
  localparam op_t OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef enum logic {
    MODE_MUL,
    MODE_DIV
  } iter_mode_e;

endpackage

// File: rtl/arith_seq_unit_if.sv
// Operand/result handshake bundle between the issuing controller and the arithmetic unit.
interface arith_seq_unit_if
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             carry;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, res_lo, res_hi, carry, zero, div_by_zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, res_lo, res_hi, carry, zero, div_by_zero
  );

endinterface

// File: rtl/arith_iter_core.sv
// Shared iterative engine: shift-add multiply and restoring divide over one 2*WIDTH register.
module arith_iter_core
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  iter_mode_e       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q;
  logic [CntW-1:0]    cnt_q;
  logic               busy_q;
  iter_mode_e         mode_q;

  logic [WIDTH:0]   shr;
  logic [WIDTH:0]   opa, opb;
  logic             cin;
  logic [WIDTH+1:0] sum;

  // For DIV the adder computes shr - b + 2^(WIDTH+1); bit WIDTH+1 set means no borrow.
  always_comb begin
    shr = acc_q[2*WIDTH-1:WIDTH-1];
    if (mode_q == MODE_DIV) begin
      opa = shr;
      opb = ~{1'b0, b_q};
      cin = 1'b1;
    end else begin
      opa = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      opb = acc_q[0] ? {1'b0, b_q} : '0;
      cin = 1'b0;
    end
    sum = {1'b0, opa} + {1'b0, opb} + {{(WIDTH + 1){1'b0}}, cin};
    if (mode_q == MODE_DIV) begin
      acc_d = sum[WIDTH+1] ? {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                           : {shr[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {sum[WIDTH:0], acc_q[WIDTH-1:1]};
    end
  end

  // Results are taken from the next-state value so the last iteration and capture coincide.
  assign done_o = busy_q && (cnt_q == '0);
  assign hi_o   = acc_d[2*WIDTH-1:WIDTH];
  assign lo_o   = acc_d[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      mode_q <= MODE_MUL;
    end else if (start_i) begin
      acc_q  <= {{WIDTH{1'b0}}, a_i};
      b_q    <= b_i;
      cnt_q  <= CntW'(WIDTH - 1);
      busy_q <= 1'b1;
      mode_q <= mode_i;
    end else if (busy_q) begin
      acc_q <= acc_d;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/arith_seq_unit.sv
// Sequential unsigned ADD/SUB/MUL/DIV unit with valid/ready handshakes and registered results.
module arith_seq_unit
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  arith_seq_unit_if.slave   bus
);

  state_e           state_q;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;
  logic             carry_q, zero_q, dbz_q, out_valid_q;

  logic [WIDTH:0]   add_sum, sub_diff;
  logic             accept, core_start, core_done;
  iter_mode_e       core_mode;
  logic [WIDTH-1:0] core_hi, core_lo;

  always_comb begin
    accept     = (state_q == ST_IDLE) && bus.in_valid;
    add_sum    = {1'b0, bus.a} + {1'b0, bus.b};
    sub_diff   = {1'b0, bus.a} - {1'b0, bus.b};
    core_mode  = (bus.op == OP_DIV) ? MODE_DIV : MODE_MUL;
    core_start = accept && ((bus.op == OP_MUL) || ((bus.op == OP_DIV) && (bus.b != '0)));
  end

  arith_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (core_start),
    .mode_i  (core_mode),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .done_o  (core_done),
    .hi_o    (core_hi),
    .lo_o    (core_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            unique case (bus.op)
              OP_ADD: begin
                res_lo_q    <= add_sum[WIDTH-1:0];
                res_hi_q    <= '0;
                carry_q     <= add_sum[WIDTH];
                zero_q      <= (add_sum[WIDTH-1:0] == '0);
                dbz_q       <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= ST_DONE;
              end
              OP_SUB: begin
                res_lo_q    <= sub_diff[WIDTH-1:0];
                res_hi_q    <= '0;
                carry_q     <= sub_diff[WIDTH];
                zero_q      <= (sub_diff[WIDTH-1:0] == '0);
                dbz_q       <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= ST_DONE;
              end
              OP_MUL: state_q <= ST_BUSY;
              OP_DIV: begin
                if (bus.b == '0) begin
                  res_lo_q    <= '1;
                  res_hi_q    <= bus.a;
                  carry_q     <= 1'b0;
                  zero_q      <= 1'b0;
                  dbz_q       <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
                end else begin
                  state_q <= ST_BUSY;
                end
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
        ST_BUSY: begin
          if (core_done) begin
            res_lo_q    <= core_lo;
            res_hi_q    <= core_hi;
            carry_q     <= 1'b0;
            zero_q      <= ({core_hi, core_lo} == '0);
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == ST_IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.res_lo      = res_lo_q;
  assign bus.res_hi      = res_hi_q;
  assign bus.carry       = carry_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_arith_seq_unit.sv
// Directed self-checking bench for arith_seq_unit at WIDTH = 8.
module tb_arith_seq_unit;
  import arith_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  arith_seq_unit_if #(.WIDTH(8)) bus ();

  arith_seq_unit #(
    .WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input int lo, input int hi, input int c,
                           input int z, input int dz);
    check({tag, " res_lo"}, 32'(bus.res_lo), lo);
    check({tag, " res_hi"}, 32'(bus.res_hi), hi);
    check({tag, " carry"}, 32'(bus.carry), c);
    check({tag, " zero"}, 32'(bus.zero), z);
    check({tag, " div_by_zero"}, 32'(bus.div_by_zero), dz);
  endtask

  // Called 1ns after a rising edge; returns after the accepting edge T, +1ns.
  task automatic send(input op_t o, input logic [7:0] x, input logic [7:0] y);
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Latency = first edge after T at which out_valid is sampled high (T+1 -> 1).
  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    n = 1;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check({tag, " in_ready after drain"}, 32'(bus.in_ready), 1);
    check({tag, " out_valid after drain"}, 32'(bus.out_valid), 0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("por in_ready", 32'(bus.in_ready), 1);
    check_res("por", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // 1. Reset in the middle of a MUL discards it.
    send(OP_MUL, 8'd200, 8'd200);
    check("mul busy in_ready", 32'(bus.in_ready), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #2;
    check("rst out_valid", 32'(bus.out_valid), 0);
    check_res("rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst release in_ready", 32'(bus.in_ready), 1);
    repeat (12) @(posedge clk);
    #1 check("rst no late result", 32'(bus.out_valid), 0);
    send(OP_ADD, 8'd2, 8'd3);
    wait_valid("add 2+3", 1);
    check_res("add 2+3", 5, 0, 0, 0, 0);
    drain("add 2+3");

    // 2. ADD wrap and SUB borrow.
    send(OP_ADD, 8'd255, 8'd1);
    wait_valid("add 255+1", 1);
    check_res("add 255+1", 'h00, 0, 1, 1, 0);
    drain("add 255+1");
    send(OP_SUB, 8'd3, 8'd5);
    wait_valid("sub 3-5", 1);
    check_res("sub 3-5", 'hFE, 0, 1, 0, 0);
    drain("sub 3-5");

    // 3. MUL.
    send(OP_MUL, 8'd200, 8'd200);
    check("mul in_ready low", 32'(bus.in_ready), 0);
    wait_valid("mul 200*200", 9);
    check("mul in_ready in done", 32'(bus.in_ready), 0);
    check_res("mul 200*200", 'h40, 'h9C, 0, 0, 0);
    drain("mul 200*200");
    send(OP_MUL, 8'd0, 8'd77);
    wait_valid("mul 0*77", 9);
    check_res("mul 0*77", 0, 0, 0, 1, 0);
    drain("mul 0*77");
    send(OP_MUL, 8'd255, 8'd255);
    wait_valid("mul 255*255", 9);
    check_res("mul 255*255", 'h01, 'hFE, 0, 0, 0);
    drain("mul 255*255");

    // 4. DIV.
    send(OP_DIV, 8'd200, 8'd7);
    wait_valid("div 200/7", 9);
    check_res("div 200/7", 'h1C, 'h04, 0, 0, 0);
    drain("div 200/7");
    send(OP_DIV, 8'd5, 8'd9);
    wait_valid("div 5/9", 9);
    check_res("div 5/9", 0, 5, 0, 0, 0);
    drain("div 5/9");
    send(OP_DIV, 8'd255, 8'd1);
    wait_valid("div 255/1", 9);
    check_res("div 255/1", 'hFF, 0, 0, 0, 0);
    drain("div 255/1");

    // 5. Divide by zero, then the flag clears on the next op.
    send(OP_DIV, 8'd17, 8'd0);
    wait_valid("div 17/0", 1);
    check_res("div 17/0", 'hFF, 'h11, 0, 0, 1);
    drain("div 17/0");
    send(OP_SUB, 8'd9, 8'd9);
    wait_valid("sub 9-9", 1);
    check_res("sub 9-9", 0, 0, 0, 1, 0);
    drain("sub 9-9");

    // 6. Back-pressure with noisy inputs, then no accept on the drain edge.
    send(OP_DIV, 8'd100, 8'd3);
    wait_valid("div 100/3", 9);
    check_res("div 100/3", 'h21, 'h01, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.op       = op_t'($urandom_range(0, 3));
      bus.a        = 8'($urandom);
      bus.b        = 8'($urandom);
      @(posedge clk);
      #1;
      check("bp out_valid", 32'(bus.out_valid), 1);
      check("bp in_ready", 32'(bus.in_ready), 0);
      check("bp res_lo", 32'(bus.res_lo), 'h21);
      check("bp res_hi", 32'(bus.res_hi), 'h01);
    end
    bus.in_valid  = 1'b1;
    bus.op        = OP_ADD;
    bus.a         = 8'd1;
    bus.b         = 8'd1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("bp drain out_valid", 32'(bus.out_valid), 0);
    check("bp drain in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check("bp next accept", 32'(bus.out_valid), 1);
    check_res("bp add 1+1", 2, 0, 0, 0, 0);
    drain("bp add 1+1");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/arith_seq_unit.md
# arith_seq_unit

Sequential, parameterised arithmetic unit: the successor to the combinational add/sub/mul/div top, generalised to any operand width.
- Executes one operation per transaction selected by an opcode:
  - ADD and SUB complete in a single cycle.
  - MUL and DIV are iterative: shift-add and restoring division.
- Uses valid/ready handshakes on both sides.
- Sits between an operand-issuing controller and a result consumer, replacing four always-on datapaths with one area-shared engine.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operands and op present.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  2  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV.
- a  in  WIDTH  operand A (dividend for DIV).
- b  in  WIDTH  operand B (divisor for DIV).
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer accepts result.
- res_lo  out  WIDTH  sum / difference / product low half / quotient.
- res_hi  out  WIDTH  0 for ADD/SUB; product high half for MUL; remainder for DIV.
- carry  out  1  ADD carry-out; SUB borrow (a < b); 0 otherwise.
- zero  out  1  {res_hi,res_lo} == 0.
- div_by_zero  out  1  DIV issued with b == 0.

## Operation
All arithmetic is unsigned.

FSM states:
- IDLE
  - in_ready = 1.
  - When in_valid is high: latch op, a and b.
  - ADD/SUB: compute into the result registers and go to DONE.
  - DIV with b == 0: load res_lo = all ones, res_hi = a, div_by_zero = 1, and go to DONE.
  - Otherwise: init the iteration counter to WIDTH-1 and go to BUSY.
- BUSY
  - One iteration per cycle.
  - MUL: if the multiplier LSB is set, add the multiplicand into the upper accumulator; then shift the 2·WIDTH accumulator right by 1.
  - DIV: shift {rem, quo} left by 1; trial-subtract b from rem; if there is no borrow, keep the difference and set the quotient LSB.
  - On the counter == 0 iteration, write the final values to the result registers and go to DONE.
- DONE
  - out_valid = 1; the result and flag registers are stable.
  - When out_ready is high: go to IDLE.
  - A new operation cannot be accepted in the same cycle as the drain.

Rules:
- Flags (carry, zero, div_by_zero) are computed together with the result and are registered alongside it.
- ADD: res_lo = (a+b) mod 2^WIDTH, carry = bit WIDTH of the sum.
- SUB: res_lo = (a−b) mod 2^WIDTH, carry = (a < b).
- MUL: {res_hi,res_lo} = a·b exactly; no overflow is possible.
- DIV: res_lo = ⌊a/b⌋, res_hi = a mod b.
- Inputs are ignored while in_ready = 0.
- out_ready is ignored while out_valid = 0.
- Reset:
  - Reset clears state to IDLE and every output register (res_lo, res_hi, carry, zero, div_by_zero, out_valid) to 0.
  - zero resets to 0, not 1.
  - Reset asserted in BUSY or DONE discards the operation; no partial result is visible.

## Timing
- Accept = in_valid & in_ready at edge T.
- ADD, SUB and DIV-by-zero: out_valid high from T+1.
- MUL and DIV: out_valid high from T+WIDTH+1 (WIDTH iterations).
- Results are held indefinitely under back-pressure (out_ready low).
- Drain at edge D → in_ready high from D+1.
- Best-case throughput is one ADD/SUB every 2 cycles.
- All outputs are driven from registers, apart from in_ready, which is decoded from the state register.
- No combinational input-to-output paths exist.

## Structure
- Shared package arith_pkg holds:
  - opcode localparams OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - FSM state encoding ST_IDLE, ST_BUSY, ST_DONE.
- Sub-module arith_iter_core:
  - contains the shared 2·WIDTH shift register, the WIDTH+1-bit adder/subtractor and the iteration counter;
  - is controlled by start/mode and returns done plus hi/lo.
  - The top level holds the FSM, the handshake, the single-cycle ADD/SUB path, the special cases and the flag registers.

## Test plan
All scenarios use WIDTH = 8.
1. Reset values: assert rst_n low mid-MUL → all outputs 0 and in_ready = 1 after release; the next ADD 2+3 gives res_lo = 5 at T+1.
2. ADD 255+1 → res_lo = 0x00, carry = 1, zero = 1, out_valid at T+1. Then SUB 3−5 → res_lo = 0xFE, carry = 1, zero = 0.
3. MUL 200·200 → res_hi = 0x9C, res_lo = 0x40, out_valid exactly at T+9, in_ready low T+1..drain. Then MUL 0·77 → zero = 1.
4. DIV 200/7 → res_lo = 0x1C, res_hi = 0x04 at T+9. Then DIV 5/9 → res_lo = 0, res_hi = 5.
5. DIV 17/0 → res_lo = 0xFF, res_hi = 0x11, div_by_zero = 1 at T+1. The next op clears div_by_zero.
6. Back-pressure: hold out_ready low 20 cycles after a DIV result → outputs stable and in_ready low, with in_valid toggling and new operands ignored. Release → one drain, then the next op is accepted at D+1.
